// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared encodings for the unified-memory arbiter: FSM state and access owner.
// Imported by mem_port_arbiter and mem_arb_lat_cnt.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// mem_arb_lat_cnt
// Loadable up-counter that times the fixed memory read latency.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset (count = 0)
//   start_i  load the count with 1 (first WAIT cycle sees 1)
//   enable_i advance the count, saturating at LAT
//   done_o   count == LAT
module mem_arb_lat_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic enable_i,
  output logic done_o
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = ONE_C;
    end else if (enable_i && (cnt_q != LAT_C)) begin
      cnt_d = cnt_q + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == LAT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the IF and DM stages.
// DM wins contention; each access runs IDLE -> ISSUE -> WAIT (LAT cycles) -> RESP.
// Optional macro MEM_ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive DM grants
// made while IF was waiting, the next arbitration goes to IF.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (held until stall drops)
//   if_rdata/if_stall             registered fetch data, fetch stall
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be  data request
//   dm_rdata/dm_stall             registered load data, data stall
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be  registered memory strobes
//   mem_rdata                     memory read data, valid LAT cycles after mem_en
//   busy                          high whenever the FSM is not in IDLE
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_stall,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_be,
  output logic [DW-1:0]   dm_rdata,
  output logic            dm_stall,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  if (LAT < 1 || (DW % 8) != 0 || STARVE_MAX < 1) begin : g_bad_params
    $error("mem_port_arbiter: illegal parameter set");
  end

  arb_state_e      state_q;
  arb_owner_e      owner_q;
  logic            store_q;
  logic            if_done_q, dm_done_q, busy_q;
  logic            mem_en_q, mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [DW/8-1:0] mem_be_q;
  logic [DW-1:0]   if_rdata_q, dm_rdata_q;

  logic req_any, grant_dm, lat_done;

  assign req_any = if_req | dm_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved  = if_req && (starve_q == STARVE_C);
  assign grant_dm = dm_req && !starved;

  // Counts DM grants that left a waiting IF behind; any other arbitration
  // outcome resets the streak. It cannot pass STARVE_C because reaching it
  // forces the next grant to IF.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && req_any) begin
      if (grant_dm && if_req) begin
        starve_d = starve_q + SW'(1);
      end else begin
        starve_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  mem_arb_lat_cnt #(
    .LAT (LAT)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .start_i  (state_q == ISSUE),
    .enable_i (state_q == WAIT),
    .done_o   (lat_done)
  );

  // RESP always returns to IDLE: the released requester still holds req in
  // that cycle, so arbitrating there would grant it a second time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      store_q     <= 1'b0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            state_q  <= ISSUE;
            busy_q   <= 1'b1;
            mem_en_q <= 1'b1;
            if (grant_dm) begin
              owner_q     <= OWN_DM;
              store_q     <= dm_we;
              mem_we_q    <= dm_we;
              mem_addr_q  <= dm_addr;
              mem_wdata_q <= dm_wdata;
              mem_be_q    <= dm_be;
            end else begin
              owner_q     <= OWN_IF;
              store_q     <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= '1;
            end
          end
        end
        ISSUE: begin
          state_q  <= WAIT;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
        WAIT: begin
          if (lat_done) begin
            state_q <= RESP;
            if (owner_q == OWN_IF) begin
              if_rdata_q <= mem_rdata;
              if_done_q  <= 1'b1;
            end else begin
              dm_done_q <= 1'b1;
              if (!store_q) begin
                dm_rdata_q <= mem_rdata;
              end
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_stall  = if_req & ~if_done_q;
  assign dm_stall  = dm_req & ~dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (LAT=2, STARVE_MAX=2). Honours
// MEM_ARB_STARVE_GUARD_EN when the design is built with it.
module tb_mem_port_arbiter;

  localparam int LAT = 2;
  localparam int SMAX = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_stall;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_stall;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        busy;

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00500093;
      32'h14:  return 32'h00A00113;
      32'h100: return 32'hCAFEF00D;
      32'h200: return 32'h11223344;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- memory model: fixed latency, junk outside the valid cycle
  logic [31:0] mem [int unsigned];
  int unsigned neg_cyc;
  int          en_count;
  typedef struct { int unsigned due; logic [31:0] data; } rd_t;
  rd_t rdq[$];

  initial begin
    int unsigned idx;
    logic [31:0] w;
    mem_rdata = '0;
    neg_cyc   = 0;
    en_count  = 0;
    forever begin
      @(negedge clk);
      neg_cyc++;
      if (mem_en) begin
        en_count++;
        idx = mem_addr >> 2;
        w = mem.exists(idx) ? mem[idx] : init_word(idx << 2);
        if (mem_we) mem[idx] = merge(w, mem_wdata, mem_be);
        else rdq.push_back('{neg_cyc + LAT, w});
      end
      if (rdq.size() > 0 && rdq[0].due == neg_cyc) begin
        mem_rdata = rdq[0].data;
        void'(rdq.pop_front());
      end else begin
        mem_rdata = $urandom();
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  // ---------------- directed single-access table
  typedef struct {
    bit          dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] dm_hold;

  task automatic run_vec(input vec_t v, input int id);
    int e0;
    tick();
    if (v.dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    e0 = en_count;
    #1;
    chk($sformatf("v%0d stall c0", id), v.dm ? dm_stall : if_stall, 1);
    for (int c = 1; c <= LAT + 2; c++) begin
      tick();
      // later changes must not reach the memory
      if_addr = ~v.addr; dm_addr = ~v.addr; dm_wdata = ~v.wdata; dm_be = ~v.be; dm_we = ~v.we;
      #1;
      chk($sformatf("v%0d mem_en c%0d", id, c), mem_en, (c == 1));
      chk($sformatf("v%0d busy c%0d", id, c), busy, 1);
      chk($sformatf("v%0d stall c%0d", id, c), v.dm ? dm_stall : if_stall, (c < LAT + 2));
      if (c == 1) begin
        chk($sformatf("v%0d mem_addr", id), mem_addr, v.addr);
        chk($sformatf("v%0d mem_we", id), mem_we, v.dm & v.we);
        if (v.dm) chk($sformatf("v%0d mem_be", id), mem_be, v.be);
        if (v.dm && v.we) chk($sformatf("v%0d mem_wdata", id), mem_wdata, v.wdata);
      end
    end
    if (!v.dm) chk($sformatf("v%0d if_rdata", id), if_rdata, v.exp_rd);
    else if (v.we) chk($sformatf("v%0d dm_rdata kept", id), dm_rdata, dm_hold);
    else begin
      chk($sformatf("v%0d dm_rdata", id), dm_rdata, v.exp_rd);
      dm_hold = v.exp_rd;
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    chk($sformatf("v%0d busy idle", id), busy, 0);
    chk($sformatf("v%0d mem_en count", id), en_count - e0, 1);
  endtask

  task automatic do_reset();
    #3 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- randomized run against a transaction-level model
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] rnd_addr();
    return 32'h40 + (32'($urandom_range(15, 0)) << 2);
  endfunction

  task automatic random_phase(input int ncyc);
    int gr = -100, dn = -100, idle_from = 0, streak = 0;
    bit own_dm = 1'b0, l_we = 1'b0, take_if, exp_en;
    logic [31:0] l_addr = '0, l_wdata = '0, l_rd = '0, exp_if = '0, exp_dm = '0, old;
    logic [3:0]  l_be = '0;
    int unsigned idx;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      // IF requester
      if (if_req && !own_dm && dn == c - 1) begin
        if ($urandom_range(1, 0) == 1) if_addr = rnd_addr(); else if_req = 1'b0;
      end else if (if_req && $urandom_range(31, 0) == 0) begin
        if_req = 1'b0;
      end else if (!if_req && $urandom_range(2, 0) == 0) begin
        if_req = 1'b1; if_addr = rnd_addr();
      end
      // DM requester
      if (dm_req && own_dm && dn == c - 1) begin
        if ($urandom_range(1, 0) == 1) begin
          dm_addr = rnd_addr(); dm_we = 1'($urandom()); dm_wdata = $urandom(); dm_be = 4'($urandom());
        end else dm_req = 1'b0;
      end else if (dm_req && $urandom_range(31, 0) == 0) begin
        dm_req = 1'b0;
      end else if (!dm_req && $urandom_range(2, 0) == 0) begin
        dm_req = 1'b1;
        dm_addr = rnd_addr(); dm_we = 1'($urandom()); dm_wdata = $urandom(); dm_be = 4'($urandom());
      end
      // the owner's inputs wander while its access is in flight
      if (c > gr && c <= dn) begin
        if (own_dm) begin
          dm_addr = rnd_addr(); dm_wdata = $urandom(); dm_be = 4'($urandom()); dm_we = 1'($urandom());
        end else if_addr = rnd_addr();
      end
      #1;
      if (c == dn) begin
        if (!own_dm) exp_if = l_rd;
        else if (!l_we) exp_dm = l_rd;
      end
      exp_en = (c == gr + 1);
      chk("rnd if_stall", if_stall, if_req && !(c == dn && !own_dm));
      chk("rnd dm_stall", dm_stall, dm_req && !(c == dn && own_dm));
      chk("rnd busy", busy, (c > gr && c <= dn));
      chk("rnd mem_en", mem_en, exp_en);
      chk("rnd mem_we", mem_we, exp_en && own_dm && l_we);
      chk("rnd if_rdata", if_rdata, exp_if);
      chk("rnd dm_rdata", dm_rdata, exp_dm);
      if (exp_en) begin
        chk("rnd mem_addr", mem_addr, l_addr);
        if (own_dm && l_we) begin
          chk("rnd mem_wdata", mem_wdata, l_wdata);
          chk("rnd mem_be", mem_be, l_be);
        end
      end
      if (c >= idle_from && (if_req || dm_req)) begin
        take_if = if_req && (!dm_req || (GUARD && streak >= SMAX));
        if (!take_if && if_req) streak++; else streak = 0;
        own_dm = !take_if;
        gr = c; dn = c + LAT + 2; idle_from = c + LAT + 3;
        l_addr = own_dm ? dm_addr : if_addr;
        l_we = own_dm && dm_we;
        l_wdata = dm_wdata;
        l_be = dm_be;
        idx = l_addr >> 2;
        old = ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx << 2);
        if (l_we) ref_mem[idx] = merge(old, l_wdata, l_be);
        else l_rd = old;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    logic [31:0] order [6];
    logic [31:0] exp_order [6];
    int got;

    rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;

    vecs[0] = '{1'b0, 1'b0, 32'h010, 32'h0,        4'hF, 32'h00500093};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        4'hF, 32'hCAFEF00D};
    vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0,        4'hF, 32'h1122BEEF};
    vecs[4] = '{1'b1, 1'b1, 32'h200, 32'h55667788, 4'b1100, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h200, 32'h0,        4'hF, 32'h5566BEEF};
    vecs[6] = '{1'b1, 1'b1, 32'h204, 32'h0BADC0DE, 4'hF, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h204, 32'h0,        4'hF, 32'h0BADC0DE};

    // reset asserted mid-cycle clears every registered output at once
    #12 rst = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_be", mem_be, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst dm_rdata", dm_rdata, 0);
    chk("rst if_stall", if_stall, 0);
    chk("rst dm_stall", dm_stall, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle mem_en", mem_en, 0);
      chk("idle busy", busy, 0);
    end

    dm_hold = '0;
    foreach (vecs[i]) run_vec(vecs[i], i);

    // contention: DM first, IF follows after a full DM occupancy
    tick();
    if_req = 1; if_addr = 32'h14; dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_be = 4'hF;
    #1;
    chk("cont if_stall c0", if_stall, 1);
    chk("cont dm_stall c0", dm_stall, 1);
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("cont mem_en c%0d", c), mem_en, (c == 1 || c == 6));
      if (c == 1) chk("cont mem_addr dm", mem_addr, 32'h100);
      if (c == 6) chk("cont mem_addr if", mem_addr, 32'h14);
      if (c <= 4) chk($sformatf("cont dm_stall c%0d", c), dm_stall, (c < 4));
      chk($sformatf("cont if_stall c%0d", c), if_stall, (c < 9));
      if (c == 4) begin
        chk("cont dm_rdata", dm_rdata, 32'hCAFEF00D);
        dm_req = 0;
      end
    end
    chk("cont if_rdata", if_rdata, 32'h00A00113);
    if_req = 0;
    tick();

    // reset during WAIT abandons the access; the held request starts over
    tick();
    if_req = 1; if_addr = 32'h10;
    tick(); tick();
    chk("mid busy before", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid busy", busy, 0);
    chk("mid mem_addr", mem_addr, 0);
    chk("mid if_rdata", if_rdata, 0);
    chk("mid dm_rdata", dm_rdata, 0);
    chk("mid if_stall", if_stall, 1);
    #3 rst = 1'b1;
    tick();
    chk("mid re mem_en", mem_en, 1);
    chk("mid re mem_addr", mem_addr, 32'h10);
    for (int c = 2; c <= LAT + 2; c++) begin
      tick();
      chk($sformatf("mid re stall c%0d", c), if_stall, (c < LAT + 2));
      chk($sformatf("mid re mem_en c%0d", c), mem_en, 0);
    end
    chk("mid re if_rdata", if_rdata, 32'h00500093);
    if_req = 0;
    tick();

`ifdef MEM_ARB_STARVE_GUARD_EN
    do_reset();
    exp_order = '{32'h100, 32'h100, 32'h10, 32'h100, 32'h100, 32'h10};
    tick();
    if_req = 1; if_addr = 32'h10; dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_be = 4'hF;
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      tick();
      if (mem_en) begin
        order[got] = mem_addr;
        got++;
      end
    end
    chk("starve grant count", got, 6);
    for (int i = 0; i < got; i++) chk($sformatf("starve grant %0d", i), order[i], exp_order[i]);
    if_req = 0; dm_req = 0;
    tick(); tick(); tick(); tick(); tick();
`endif

    do_reset();
    random_phase(3000);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
